// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctl_pkg;

    // Controller FSM: normal issue, or holding the pipe for a multi-cycle multiply.
    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_e;

    localparam int REG_AW_DEF  = 5;   // default register-address width
    localparam int STALL_CNT_W = 16;  // width of the saturating stall counter
    localparam int MUL_CNT_W   = 4;   // enough for MUL_CYCLES up to 15

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle of pipeline-stage inputs and hazard/flush controls.
// master: the datapath (drives stage info, receives controls).
// slave : the hazard controller.
interface pipe_hazard_ctl_if
    import pipe_ctl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    // ID-stage sources
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    // EX-stage producer
    logic [REG_AW-1:0]      ex_rd;
    logic                   ex_regwrite;
    logic                   ex_load;
    logic                   ex_mul;
    logic                   branch_taken;
    // MEM-stage producer
    logic [REG_AW-1:0]      mem_rd;
    logic                   mem_regwrite;
    // Controls back to the datapath
    logic                   pc_stall;
    logic                   ifid_stall;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   ex_stall;
    logic                   exmem_flush;
    logic                   mul_busy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_regwrite, ex_load, ex_mul, branch_taken,
               mem_rd, mem_regwrite,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush,
               ex_stall, exmem_flush, mul_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_regwrite, ex_load, ex_mul, branch_taken,
               mem_rd, mem_regwrite,
        output pc_stall, ifid_stall, ifid_flush, idex_flush,
               ex_stall, exmem_flush, mul_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_cmp.sv
// One source-versus-destination dependency check: the source is really read,
// the destination is really written, the addresses match, and the register
// is not the hard-wired zero register.
module hazard_cmp #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_i,
    input  logic          src_use_i,
    input  logic [AW-1:0] dst_i,
    input  logic          dst_we_i,
    output logic          match_o
);

    assign match_o = src_use_i && dst_we_i && (src_i != '0) && (src_i == dst_i);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flushes and a
// multi-cycle multiply hold in EX, plus a saturating count of PC-stall cycles.
// Build option PIPE_FORWARD_EN: with full forwarding only a load in EX can
// cause a bubble; without it, any pending EX or MEM write to a source stalls.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,          // EX multiply latency, 1..15
    parameter int REG_AW     = REG_AW_DEF
) (
    input  logic             clk,
    input  logic             reset,        // synchronous, active high
    pipe_hazard_ctl_if.slave bus
);

    // A 1-cycle multiply never needs the hold state.
    localparam bit                   MUL_EN   = (MUL_CYCLES > 1);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_EN ? MUL_CNT_W'(MUL_CYCLES - 2) : '0;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_e                 state_q;
    logic [MUL_CNT_W-1:0]   mul_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // ------------------------------------------------------------------
    // Which in-flight destinations can still be a hazard
    // ------------------------------------------------------------------
    logic ex_we;
    logic mem_we;
    logic unused_cfg;

`ifdef PIPE_FORWARD_EN
    // Forwarding covers everything except data still coming back from memory.
    assign ex_we      = bus.ex_regwrite & bus.ex_load;
    assign mem_we     = 1'b0;
    assign unused_cfg = bus.mem_regwrite;
`else
    // No bypass: wait until the producer has written the register file.
    assign ex_we      = bus.ex_regwrite;
    assign mem_we     = bus.mem_regwrite;
    assign unused_cfg = bus.ex_load;
`endif

    logic rs1_ex_hit;
    logic rs2_ex_hit;
    logic rs1_mem_hit;
    logic rs2_mem_hit;

    hazard_cmp #(.AW(REG_AW)) u_rs1_ex (
        .src_i    (bus.id_rs1),
        .src_use_i(bus.id_use_rs1),
        .dst_i    (bus.ex_rd),
        .dst_we_i (ex_we),
        .match_o  (rs1_ex_hit)
    );

    hazard_cmp #(.AW(REG_AW)) u_rs2_ex (
        .src_i    (bus.id_rs2),
        .src_use_i(bus.id_use_rs2),
        .dst_i    (bus.ex_rd),
        .dst_we_i (ex_we),
        .match_o  (rs2_ex_hit)
    );

    hazard_cmp #(.AW(REG_AW)) u_rs1_mem (
        .src_i    (bus.id_rs1),
        .src_use_i(bus.id_use_rs1),
        .dst_i    (bus.mem_rd),
        .dst_we_i (mem_we),
        .match_o  (rs1_mem_hit)
    );

    hazard_cmp #(.AW(REG_AW)) u_rs2_mem (
        .src_i    (bus.id_rs2),
        .src_use_i(bus.id_use_rs2),
        .dst_i    (bus.mem_rd),
        .dst_we_i (mem_we),
        .match_o  (rs2_mem_hit)
    );

    logic data_hazard;
    logic branch_eff;

    assign data_hazard = rs1_ex_hit | rs2_ex_hit | rs1_mem_hit | rs2_mem_hit;
    // A multiply issuing in EX takes precedence over a branch resolving there.
    assign branch_eff  = bus.branch_taken & ~bus.ex_mul;

    // ------------------------------------------------------------------
    // FSM: enter MUL for the remaining multiply cycles, count down, return
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before this edge regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (MUL_EN && bus.ex_mul) begin
                        state_q   <= MUL;
                        mul_cnt_q <= MUL_LOAD;
                    end
                end
                MUL: begin
                    if (mul_cnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    mul_cnt_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency stall/flush decode from state and current stage info
    // ------------------------------------------------------------------
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic ex_stall;
    logic exmem_flush;
    logic mul_busy;

    // Priority: reset, multiply hold, branch flush, data-hazard bubble.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ex_stall    = 1'b0;
        exmem_flush = 1'b0;
        mul_busy    = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == MUL) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            ex_stall    = 1'b1;
            exmem_flush = 1'b1;
            mul_busy    = 1'b1;
        end else if (branch_eff) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (data_hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.ifid_stall   = ifid_stall;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.ex_stall     = ex_stall;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.mul_busy     = mul_busy;
    assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: directed corner cases followed by
// randomized stage traffic, compared against a behavioural model that works
// from the hazard rules (producer lists, remaining multiply cycles) each cycle.
module tb_pipe_hazard_ctl;
    import pipe_ctl_pkg::*;

    localparam int MUL_CYCLES = 4;
    localparam int REG_AW     = 5;
    localparam int SAT_MAX    = 65535;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctl_if #(.REG_AW(REG_AW)) bus ();

    pipe_hazard_ctl #(
        .MUL_CYCLES(MUL_CYCLES),
        .REG_AW    (REG_AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: multiply-hold cycles still owed, and the stall tally.
    int busy_left   = 0;
    int stall_model = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // True when some read source waits on a register that is still in flight.
    function automatic bit model_hazard();
        logic [REG_AW-1:0] dst[$];
        logic [REG_AW-1:0] src[$];
`ifdef PIPE_FORWARD_EN
        if (bus.ex_regwrite && bus.ex_load) dst.push_back(bus.ex_rd);
`else
        if (bus.ex_regwrite)  dst.push_back(bus.ex_rd);
        if (bus.mem_regwrite) dst.push_back(bus.mem_rd);
`endif
        if (bus.id_use_rs1) src.push_back(bus.id_rs1);
        if (bus.id_use_rs2) src.push_back(bus.id_rs2);
        foreach (src[i]) begin
            if (src[i] != 0) begin
                foreach (dst[j]) begin
                    if (src[i] == dst[j]) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Expected {pc_stall, ifid_stall, ifid_flush, idex_flush, ex_stall, exmem_flush, mul_busy}.
    function automatic logic [6:0] model_outputs();
        if (reset)                                  return 7'b0011010;
        if (busy_left > 0)                          return 7'b1100111;
        if (bus.branch_taken && !bus.ex_mul)        return 7'b0011000;
        if (model_hazard())                         return 7'b1101000;
        return 7'b0000000;
    endfunction

    // One clock: compare mid-cycle, then advance the model across the edge.
    task automatic step(input string tag, input bit do_check = 1'b1);
        logic [6:0] exp_v;
        logic [6:0] got_v;
        #1;
        exp_v = model_outputs();
        got_v = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_flush,
                 bus.ex_stall, bus.exmem_flush, bus.mul_busy};
        if (do_check) begin
            check({tag, "/ctl"}, 32'(got_v), 32'(exp_v));
            check({tag, "/cnt"}, 32'(bus.stall_cycles), 32'(stall_model));
        end
        @(posedge clk);
        if (reset) begin
            busy_left   = 0;
            stall_model = 0;
        end else begin
            if (exp_v[6] && stall_model < SAT_MAX) stall_model++;
            if (busy_left > 0) busy_left--;
            else if (bus.ex_mul && MUL_CYCLES > 1) busy_left = MUL_CYCLES - 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_use_rs1   = 1'b0;
        bus.id_use_rs2   = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_load      = 1'b0;
        bus.ex_mul       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_rd       = '0;
        bus.mem_regwrite = 1'b0;
    endtask

    task automatic set_load_use(input logic [REG_AW-1:0] rd, input bit on_rs2);
        bus.ex_rd       = rd;
        bus.ex_regwrite = 1'b1;
        bus.ex_load     = 1'b1;
        if (on_rs2) begin
            bus.id_rs2     = rd;
            bus.id_use_rs2 = 1'b1;
        end else begin
            bus.id_rs1     = rd;
            bus.id_use_rs1 = 1'b1;
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Two reset cycles: flushes asserted, stalls low, counter cleared.
        step("rst0", 1'b0);
        step("rst1");
        reset = 1'b0;
        step("idle");

        // Load-use on rs1 = 3 gives one bubble.
        set_load_use(REG_AW'(3), 1'b0);
        step("load_use");
        // Same dependency without a load: stalls only without forwarding.
        bus.ex_load = 1'b0;
        step("ex_noload");
        // Dependency through MEM only.
        idle_inputs();
        bus.id_rs2 = REG_AW'(9); bus.id_use_rs2 = 1'b1;
        bus.mem_rd = REG_AW'(9); bus.mem_regwrite = 1'b1;
        step("mem_dep");
        // Matching address but source not used.
        bus.id_use_rs2 = 1'b0;
        step("mem_nouse");
        idle_inputs();

        // Single multiply from a clean counter: exactly three hold cycles.
        reset = 1'b1;
        step("rst_mul");
        reset = 1'b0;
        bus.ex_mul = 1'b1;
        step("mul_issue");
        idle_inputs();
        step("mul_b1");
        step("mul_b2");
        step("mul_b3");
        step("mul_done");
        check("mul_stall_total", 32'(bus.stall_cycles), 32'd3);

        // Branch together with load-use on rs2 = 7: flush wins, no stall.
        set_load_use(REG_AW'(7), 1'b1);
        bus.branch_taken = 1'b1;
        step("branch_lu");
        check("branch_cnt_kept", 32'(bus.stall_cycles), 32'd3);
        idle_inputs();

        // Register zero never causes a hazard.
        set_load_use(REG_AW'(0), 1'b0);
        step("rs_zero");
        idle_inputs();

        // Multiply and branch together: multiply wins, branch ignored.
        bus.ex_mul = 1'b1; bus.branch_taken = 1'b1;
        step("mul_vs_br");
        // Hazard and branch inputs are ignored while holding.
        set_load_use(REG_AW'(4), 1'b0);
        bus.ex_mul = 1'b0;
        step("mul_ign1");
        idle_inputs();
        step("mul_ign2");
        step("mul_ign3");
        step("mul_ign_done");

        // Reset in the second hold cycle aborts the multiply.
        bus.ex_mul = 1'b1;
        step("mul_a0");
        idle_inputs();
        step("mul_a1");
        reset = 1'b1;
        step("mul_a2_rst");
        reset = 1'b0;
        step("after_abort");
        check("abort_busy", 32'(bus.mul_busy), 32'd0);
        check("abort_cnt", 32'(bus.stall_cycles), 32'd0);

        // Long forced stall saturates the counter.
        set_load_use(REG_AW'(5), 1'b0);
        for (int i = 0; i < 70000; i++) step("sat_run", 1'b0);
        step("sat_end");
        check("sat_value", 32'(bus.stall_cycles), 32'h0000_FFFF);
        idle_inputs();

        // Randomized traffic on a small register window to provoke collisions.
        reset = 1'b1;
        step("rst_rand");
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            bus.id_rs1       = REG_AW'($urandom_range(0, 3));
            bus.id_rs2       = REG_AW'($urandom_range(0, 3));
            bus.id_use_rs1   = 1'($urandom_range(0, 1));
            bus.id_use_rs2   = 1'($urandom_range(0, 1));
            bus.ex_rd        = REG_AW'($urandom_range(0, 3));
            bus.ex_regwrite  = 1'($urandom_range(0, 1));
            bus.ex_load      = 1'($urandom_range(0, 1));
            bus.ex_mul       = ($urandom_range(0, 7) == 0);
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.mem_rd       = REG_AW'($urandom_range(0, 3));
            bus.mem_regwrite = 1'($urandom_range(0, 1));
            reset            = ($urandom_range(0, 39) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
